// File: rtl/imem_pkg.sv
// Shared state encoding and fixed words for the instruction-memory loader.
// Only types and constants live here; nothing here has latency or flow control.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_ram.sv
// DEPTH x 32 instruction store: one synchronous write port, one registered read port.
// Read data appears one edge after re; no backpressure, storage is never reset.
module instr_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads debug-bus words into the instruction RAM, holds the core in reset until start, then serves fetches.
// Fetch latency 1 cycle, one request per cycle accepted, no backpressure on either bus.
module imem_loader
  import imem_pkg::*;
#(
  parameter int  DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          debug_sig,
  input  logic [31:0]   debug_addr,
  input  logic [31:0]   debug_instr,
  input  logic          start,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_pc,
  output logic [31:0]   fetch_instr,
  output logic          fetch_valid,
  output logic          fetch_err,
  output logic          core_nrst,
  output logic [AW:0]   loaded_count,
  output logic          load_err
);

  state_t      state_q;
  state_t      state_d;
  logic        wr_in_range;
  logic        wr_accept;
  logic        wr_illegal;
  logic        fetch_go;
  logic        pc_bad;
  logic        ram_sel;
  logic [31:0] ram_rdata;

  assign wr_in_range = debug_addr < 32'(DEPTH);
  assign wr_accept   = debug_sig && (state_q != RUN) && wr_in_range;
  assign wr_illegal  = debug_sig &&
                       ((state_q == RUN) || (!wr_in_range && (debug_addr != IDLE_ADDR)));

  assign fetch_go = fetch_req && (state_q == RUN);
  assign pc_bad   = (fetch_pc[1:0] != 2'b00) || (fetch_pc[31:AW+2] != '0);

  instr_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (debug_addr[AW-1:0]),
    .wdata (debug_instr),
    .re    (fetch_go && !pc_bad),
    .raddr (fetch_pc[AW+1:2]),
    .rdata (ram_rdata)
  );

  // start wins over debug_sig; a same-cycle write still commits through wr_accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start)          state_d = RUN;
        else if (debug_sig) state_d = LOAD;
      end
      LOAD: begin
        if (start)           state_d = RUN;
        else if (!debug_sig) state_d = ARMED;
      end
      ARMED: begin
        if (start)          state_d = RUN;
        else if (debug_sig) state_d = LOAD;
      end
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      core_nrst    <= 1'b0;
      fetch_valid  <= 1'b0;
      fetch_err    <= 1'b0;
      ram_sel      <= 1'b0;
      loaded_count <= '0;
      load_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_nrst   <= (state_q == RUN);
      fetch_valid <= fetch_go;
      fetch_err   <= fetch_go && pc_bad;
      ram_sel     <= fetch_go && !pc_bad;
      if (wr_accept && (loaded_count != (AW+1)'(DEPTH))) begin
        loaded_count <= loaded_count + 1'b1;
      end
      if (wr_illegal) begin
        load_err <= 1'b1;
      end
    end
  end

  // RAM output register has no reset, so the NOP path covers reset and errored fetches.
  assign fetch_instr = ram_sel ? ram_rdata : NOP_INSTR;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a fetch scoreboard checked on the falling edge.
module tb_imem_loader;

  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        nrst;
  logic        debug_sig;
  logic [31:0] debug_addr;
  logic [31:0] debug_instr;
  logic        start;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_valid;
  logic        fetch_err;
  logic        core_nrst;
  logic [10:0] loaded_count;
  logic        load_err;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .debug_sig    (debug_sig),
    .debug_addr   (debug_addr),
    .debug_instr  (debug_instr),
    .start        (start),
    .fetch_req    (fetch_req),
    .fetch_pc     (fetch_pc),
    .fetch_instr  (fetch_instr),
    .fetch_valid  (fetch_valid),
    .fetch_err    (fetch_err),
    .core_nrst    (core_nrst),
    .loaded_count (loaded_count),
    .load_err     (load_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] exp, input logic err);
    exp_t e;
    e.instr = exp;
    e.err   = err;
    e.due   = cyc + 1;
    fetch_req = 1'b1;
    fetch_pc  = pc;
    sb.push_back(e);
    step();
    fetch_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    debug_sig   = 1'b1;
    debug_addr  = addr;
    debug_instr = data;
    step();
  endtask

  // Fetch responses are popped in order and must land exactly one cycle after the request.
  always @(negedge clk) begin
    exp_t e;
    if (fetch_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_fetch_valid", {31'b0, fetch_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("fetch_instr", fetch_instr, e.instr);
        chk("fetch_err", {31'b0, fetch_err}, {31'b0, e.err});
        chk("fetch_latency", cyc, e.due);
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      chk("fetch_valid_missing", {31'b0, fetch_valid}, 32'd1);
      void'(sb.pop_front());
    end
  end

  initial begin
    nrst = 1'b0; debug_sig = 1'b0; debug_addr = 32'hFFFF_FFFF; debug_instr = '0;
    start = 1'b0; fetch_req = 1'b0; fetch_pc = '0;
    step(); step();
    chk("rst_core_nrst", {31'b0, core_nrst}, 32'd0);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_fetch_instr", fetch_instr, NOP);
    chk("rst_loaded_count", {21'b0, loaded_count}, 32'd0);
    chk("rst_load_err", {31'b0, load_err}, 32'd0);
    nrst = 1'b1;

    // Phase 1: load 0..9 with a fetch request held high that must be ignored.
    fetch_req = 1'b1;
    fetch_pc  = 32'h0;
    for (int i = 0; i < 10; i++) begin
      wr(i, 32'h100 + i);
      chk("no_fetch_in_load", {31'b0, fetch_valid}, 32'd0);
    end
    fetch_req = 1'b0;
    debug_sig = 1'b0;
    step();
    chk("count_after_load", {21'b0, loaded_count}, 32'd10);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("core_nrst_edge_n", {31'b0, core_nrst}, 32'd0);
    step();
    chk("core_nrst_edge_n1", {31'b0, core_nrst}, 32'd1);
    do_fetch(32'h24, 32'h109, 1'b0);
    do_fetch(32'h2, NOP, 1'b1);
    do_fetch(32'h1000, NOP, 1'b1);
    step();
    do_fetch(32'h0, 32'h100, 1'b0);
    do_fetch(32'h4, 32'h101, 1'b0);
    do_fetch(32'h8, 32'h102, 1'b0);
    step();
    chk("load_err_before_run_write", {31'b0, load_err}, 32'd0);
    wr(32'd3, 32'hDEAD_BEEF);
    debug_sig = 1'b0;
    chk("load_err_run_write", {31'b0, load_err}, 32'd1);
    chk("count_run_write", {21'b0, loaded_count}, 32'd10);
    do_fetch(32'hC, 32'h103, 1'b0);
    step();

    // Phase 2: reset in RUN, illegal and idle-marker writes, start with a same-cycle write.
    nrst = 1'b0;
    step();
    chk("rst_run_core_nrst", {31'b0, core_nrst}, 32'd0);
    chk("rst_run_count", {21'b0, loaded_count}, 32'd0);
    chk("rst_run_load_err", {31'b0, load_err}, 32'd0);
    nrst = 1'b1;
    fetch_req = 1'b1;
    fetch_pc  = 32'h24;
    step();
    fetch_req = 1'b0;
    chk("no_fetch_in_idle", {31'b0, fetch_valid}, 32'd0);
    wr(32'hFFFF_FFFF, 32'hBAD0_0001);
    chk("idle_marker_err", {31'b0, load_err}, 32'd0);
    chk("idle_marker_count", {21'b0, loaded_count}, 32'd0);
    wr(DEPTH, 32'hBAD0_0002);
    chk("oor_err", {31'b0, load_err}, 32'd1);
    chk("oor_count", {21'b0, loaded_count}, 32'd0);
    wr(32'hFFFF_FFFF, 32'hBAD0_0003);
    chk("oor_err_held", {31'b0, load_err}, 32'd1);
    chk("idle_marker_count2", {21'b0, loaded_count}, 32'd0);
    debug_sig = 1'b0;
    step();
    start = 1'b1;
    wr(32'd5, 32'hABCD_0013);
    start = 1'b0;
    debug_sig = 1'b0;
    chk("same_cycle_count", {21'b0, loaded_count}, 32'd1);
    chk("same_cycle_core_nrst", {31'b0, core_nrst}, 32'd0);
    step();
    chk("same_cycle_core_nrst_up", {31'b0, core_nrst}, 32'd1);
    do_fetch(32'h14, 32'hABCD_0013, 1'b0);
    do_fetch(32'h24, 32'h109, 1'b0);
    do_fetch(32'h0, 32'h100, 1'b0);
    step();

    // Phase 3: counter saturation over a full sweep plus one extra write.
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr(i, 32'h100 + i);
    end
    chk("count_full", {21'b0, loaded_count}, DEPTH);
    wr(32'd0, 32'h100);
    debug_sig = 1'b0;
    chk("count_saturated", {21'b0, loaded_count}, DEPTH);
    chk("sweep_load_err", {31'b0, load_err}, 32'd0);
    step();
    step();
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program-memory stage directly downstream of the debug program loader. Captures the instruction words streamed on the debug load bus into an on-chip instruction RAM and holds the core in reset while loading. When the loader raises `start`, it releases the core and serves instruction fetches from the loaded image. It is the single owner of the instruction store between the debug path and the fetch stage.

## Interface
- `DEPTH`, 1024: instruction words stored; must be a power of two.
- `AW`, $clog2(DEPTH): word-index width, derived; do not override.
- `clk` in 1: single clock; all logic is on the rising edge.
- `nrst` in 1: reset, synchronous, active-low.
- `debug_sig` in 1: load-write valid; one word per cycle while high.
- `debug_addr` in 32: word index of `debug_instr`; value 32'hFFFF_FFFF is the idle marker.
- `debug_instr` in 32: instruction word to store.
- `start` in 1: loader finished; level, sampled each cycle.
- `fetch_req` in 1: fetch request from the core.
- `fetch_pc` in 32: byte address of the fetch.
- `fetch_instr` out 32: fetched instruction, registered.
- `fetch_valid` out 1: `fetch_instr` valid this cycle.
- `fetch_err` out 1: the fetch returned this cycle was misaligned or out of range.
- `core_nrst` out 1: reset to the core, active-low.
- `loaded_count` out AW+1: number of accepted writes, saturating at DEPTH.
- `load_err` out 1: sticky illegal-write flag.

## Operation
- State machine: IDLE → LOAD → ARMED → RUN. RUN is left only by reset.
  - IDLE: on `debug_sig`=1 go to LOAD; on `start`=1 go to RUN, and the core then runs whatever the RAM holds.
  - LOAD: on `start`=1 go to RUN; else on `debug_sig`=0 go to ARMED.
  - ARMED: on `debug_sig`=1 go back to LOAD; on `start`=1 go to RUN.
- Write acceptance:
  - A write is accepted when `debug_sig`=1, the state is IDLE, LOAD or ARMED, and `debug_addr` < DEPTH.
  - An accepted write stores `debug_instr` at `debug_addr[AW-1:0]` and increments `loaded_count`.
  - Rewriting an address overwrites it and still counts.
- A write with `debug_addr`=32'hFFFF_FFFF is dropped silently.
- Any other write with `debug_addr` ≥ DEPTH is dropped and sets `load_err`.
- `debug_sig`=1 while in RUN is ignored and sets `load_err`.
- `start` and `debug_sig` high in the same cycle: the write commits, then the state goes to RUN.
- Fetch:
  - Served only in RUN.
  - Word index is `fetch_pc[AW+1:2]`.
  - If `fetch_pc[1:0]` ≠ 0 or `fetch_pc[31:AW+2]` ≠ 0, the fetch returns NOP (32'h0000_0013) with `fetch_err`=1.
  - `fetch_req` outside RUN is ignored: no valid, no error.
- RAM contents are not cleared by reset.

## Timing
- Reset values: state IDLE, `core_nrst`=0, `fetch_valid`=0, `fetch_err`=0, `fetch_instr`=32'h0000_0013, `loaded_count`=0, `load_err`=0.
- Write: a write accepted at edge N is readable by a fetch presented at edge N+1 or later.
- `core_nrst` is registered from state==RUN. If `start` is sampled high at edge N, the state is RUN after N and `core_nrst` goes to 1 after edge N+1.
- Fetch latency is 1 cycle:
  - `fetch_req` sampled at edge N gives `fetch_instr`, `fetch_valid` and `fetch_err` after edge N, held for one cycle.
  - Back-to-back requests are accepted every cycle.
- `fetch_valid` pulses for one cycle per request; there is no backpressure.
- `loaded_count` updates at the edge that commits the write and holds at DEPTH once it saturates.
- Reset mid-load returns the state to IDLE and clears the counters and flags. Words already written stay in the RAM.

## Structure
- Package `imem_pkg`: the state enum (IDLE, LOAD, ARMED, RUN) and the constants NOP_INSTR=32'h0000_0013 and IDLE_ADDR=32'hFFFF_FFFF.
- Sub-module `instr_ram`: one synchronous write port and one registered read port, DEPTH×32, with no reset on the storage array.
- The top level holds the FSM, the address checks, the counters and the `core_nrst` register.

## Test plan
- Load words 0..9 (`debug_addr` 0..9, data 32'h100+i), then `start`=1 → `loaded_count`=10; `core_nrst` rises 2 edges after `start` is sampled; a fetch at pc 0x24 returns 32'h109 one cycle later with `fetch_valid`=1.
- Write at `debug_addr`=DEPTH (1024) → no store, `load_err`=1 and held; write at 32'hFFFF_FFFF → `load_err` unchanged, count unchanged.
- `start` and `debug_sig` both high with addr 5, data 32'hABCD_0013 → a fetch at pc 0x14 in RUN returns 32'hABCD_0013.
- In RUN: fetch at pc 0x2 → NOP, `fetch_err`=1; fetch at pc 0x1000 (DEPTH=1024) → NOP, `fetch_err`=1; `debug_sig`=1 → `load_err`=1 and RAM unchanged.
- `fetch_req` high in LOAD → `fetch_valid` stays 0. Assert reset in RUN → `core_nrst`=0 and state IDLE at the next edge; after re-entering RUN, earlier RAM contents are still returned.
- Back-to-back fetches at pc 0, 4, 8 → three consecutive `fetch_valid` cycles with the matching words.
